// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline sequencing controller and the 3-stage core:
// hazard/request inputs plus register enables, flush and status outputs.
interface pipe_ctrl_if #(
   parameter int unsigned CW = 16
);
   logic          halt;
   logic          mem_req;
   logic          mem_ack;
   logic          branch_taken;
   logic          ld_use_hazard;
   logic          pc_ld;
   logic          ifid_ld;
   logic          idex_ld;
   logic          ifid_flush;
   logic          idex_flush;
   logic          mem_go;
   logic          err;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt;

   modport master (
      input  halt, mem_req, mem_ack, branch_taken, ld_use_hazard,
      output pc_ld, ifid_ld, idex_ld, ifid_flush, idex_flush, mem_go, err,
             state_o, stall_cnt
   );

   modport slave (
      output halt, mem_req, mem_ack, branch_taken, ld_use_hazard,
      input  pc_ld, ifid_ld, idex_ld, ifid_flush, idex_flush, mem_go, err,
             state_o, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: resolves halt, memory wait, branch flush and
// load-use stalls into register enables/flushes; counts stall cycles.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CW      = 16
) (
   input  logic              clk,
   input  logic              clr,
   pipe_ctrl_if.master       bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2,
      ERR      = 2'd3
   } state_e;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [7:0]    wait_q, wait_d;
   logic [CW-1:0] stall_q, stall_d;

   logic pc_ld_c, ifid_ld_c, idex_ld_c, ifid_flush_c, idex_flush_c, mem_go_c;

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      pc_ld_c      = 1'b0;
      ifid_ld_c    = 1'b0;
      idex_ld_c    = 1'b0;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      mem_go_c     = 1'b0;

      case (state_q)
         RUN: begin
            if (bus.halt) begin
               state_d = HALT;
            end else if (bus.mem_req) begin
               mem_go_c = 1'b1;
               state_d  = MEM_WAIT;
               wait_d   = '0;
            end else if (bus.branch_taken) begin
               pc_ld_c      = 1'b1;
               ifid_ld_c    = 1'b1;
               idex_ld_c    = 1'b1;
               ifid_flush_c = 1'b1;
               idex_flush_c = 1'b1;
            end else if (bus.ld_use_hazard) begin
               // Hold fetch, inject one bubble into ID/EX.
               idex_ld_c    = 1'b1;
               idex_flush_c = 1'b1;
            end else begin
               pc_ld_c   = 1'b1;
               ifid_ld_c = 1'b1;
               idex_ld_c = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ack) begin
               state_d = RUN;
            end else if (wait_q == TO_LAST) begin
               state_d = ERR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         HALT: begin
            if (!bus.halt) begin
               state_d = RUN;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      stall_d = stall_q;
      if ((state_q == RUN || state_q == MEM_WAIT) && !pc_ld_c && stall_q != '1) begin
         stall_d = stall_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= RUN;
         wait_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
      end
   end

   // Combinational outputs are gated so clr forces them low without a clock edge.
   assign bus.pc_ld      = pc_ld_c      & ~clr;
   assign bus.ifid_ld    = ifid_ld_c    & ~clr;
   assign bus.idex_ld    = idex_ld_c    & ~clr;
   assign bus.ifid_flush = ifid_flush_c & ~clr;
   assign bus.idex_flush = idex_flush_c & ~clr;
   assign bus.mem_go     = mem_go_c     & ~clr;
   assign bus.err        = (state_q == ERR) & ~clr;
   assign bus.state_o    = state_q;
   assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (default, and TIMEOUT=3/CW=2)
// driven by directed vectors with hand-computed expected outputs.
module tb_pipe_ctrl;

   logic clk;
   logic clr_a, clr_b;

   pipe_ctrl_if #(.CW(16)) ifa ();
   pipe_ctrl_if #(.CW(2))  ifb ();

   pipe_ctrl #(.TIMEOUT(16), .CW(16)) dut_a (.clk(clk), .clr(clr_a), .bus(ifa.master));
   pipe_ctrl #(.TIMEOUT(3),  .CW(2))  dut_b (.clk(clk), .clr(clr_b), .bus(ifb.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          b;
      string       name;
      logic [6:0]  o;    // {pc_ld, ifid_ld, idex_ld, ifid_flush, idex_flush, mem_go, err}
      logic [1:0]  st;
      logic [15:0] sc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic set_in(input bit b, input logic [4:0] v);
      if (!b) begin
         {ifa.halt, ifa.mem_req, ifa.mem_ack, ifa.branch_taken, ifa.ld_use_hazard} = v;
      end else begin
         {ifb.halt, ifb.mem_req, ifb.mem_ack, ifb.branch_taken, ifb.ld_use_hazard} = v;
      end
   endtask

   // in = {halt, mem_req, mem_ack, branch_taken, ld_use_hazard}
   task automatic step(input bit b, input string nm, input logic c, input logic [4:0] in,
                       input logic [2:0] ld, input logic [1:0] fl, input logic go,
                       input logic er, input logic [1:0] st, input logic [15:0] sc);
      exp_t e;
      @(posedge clk);
      #1;
      set_in(b, in);
      set_in(!b, 5'b00000);
      if (!b) clr_a = c;
      else    clr_b = c;
      e.b    = b;
      e.name = nm;
      e.o    = {ld, fl, go, er};
      e.st   = st;
      e.sc   = sc;
      sb.push_back(e);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t        e;
            logic [6:0]  ao;
            logic [1:0]  ast;
            logic [15:0] asc;
            e = sb.pop_front();
            if (!e.b) begin
               ao  = {ifa.pc_ld, ifa.ifid_ld, ifa.idex_ld, ifa.ifid_flush, ifa.idex_flush,
                      ifa.mem_go, ifa.err};
               ast = ifa.state_o;
               asc = ifa.stall_cnt;
            end else begin
               ao  = {ifb.pc_ld, ifb.ifid_ld, ifb.idex_ld, ifb.ifid_flush, ifb.idex_flush,
                      ifb.mem_go, ifb.err};
               ast = ifb.state_o;
               asc = 16'(ifb.stall_cnt);
            end
            n_cmp++;
            if (ao !== e.o || ast !== e.st || asc !== e.sc) begin
               n_fail++;
               $display("FAIL %s: got outs=%b state=%0d stall=%0d, expected outs=%b state=%0d stall=%0d",
                        e.name, ao, ast, asc, e.o, e.st, e.sc);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      clr_a = 1'b1;
      clr_b = 1'b1;
      set_in(0, 5'b00000);
      set_in(1, 5'b00000);

      // Instance A: TIMEOUT=16, CW=16
      step(0, "a_reset",      1, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd0, 16'd0);
      step(0, "a_idle",       0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd0);
      step(0, "a_br_lu",      0, 5'b00011, 3'b111, 2'b11, 0, 0, 2'd0, 16'd0);
      step(0, "a_after_br",   0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd0);
      step(0, "a_lu1",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd0);
      step(0, "a_lu2",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd1);
      step(0, "a_lu3",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd2);
      step(0, "a_lu_done",    0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd3);
      step(0, "a_mreq",       0, 5'b01000, 3'b000, 2'b00, 1, 0, 2'd0, 16'd3);
      step(0, "a_mw1",        0, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd1, 16'd4);
      step(0, "a_mw2_ign",    0, 5'b10010, 3'b000, 2'b00, 0, 0, 2'd1, 16'd5);
      step(0, "a_mw3",        0, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd1, 16'd6);
      step(0, "a_mw4_ack",    0, 5'b00100, 3'b000, 2'b00, 0, 0, 2'd1, 16'd7);
      step(0, "a_post_mem",   0, 5'b00100, 3'b111, 2'b00, 0, 0, 2'd0, 16'd8);
      step(0, "a_halt_mreq",  0, 5'b11000, 3'b000, 2'b00, 0, 0, 2'd0, 16'd8);
      step(0, "a_halt_hold",  0, 5'b10000, 3'b000, 2'b00, 0, 0, 2'd2, 16'd9);
      step(0, "a_halt_drop",  0, 5'b01000, 3'b000, 2'b00, 0, 0, 2'd2, 16'd9);
      step(0, "a_mreq_go",    0, 5'b01000, 3'b000, 2'b00, 1, 0, 2'd0, 16'd9);
      step(0, "a_mw_ack",     0, 5'b00100, 3'b000, 2'b00, 0, 0, 2'd1, 16'd10);
      step(0, "a_run",        0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd11);
      step(0, "a_mreq2",      0, 5'b01000, 3'b000, 2'b00, 1, 0, 2'd0, 16'd11);
      step(0, "a_mw_wait",    0, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd1, 16'd12);
      step(0, "a_clr_async",  1, 5'b01000, 3'b000, 2'b00, 0, 0, 2'd0, 16'd0);
      step(0, "a_after_clr",  0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd0);

      // Instance B: TIMEOUT=3, CW=2
      step(1, "b_reset",      1, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd0, 16'd0);
      step(1, "b_mreq",       0, 5'b01000, 3'b000, 2'b00, 1, 0, 2'd0, 16'd0);
      step(1, "b_mw0",        0, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd1, 16'd1);
      step(1, "b_mw1",        0, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd1, 16'd2);
      step(1, "b_mw2",        0, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd1, 16'd3);
      step(1, "b_err",        0, 5'b00000, 3'b000, 2'b00, 0, 1, 2'd3, 16'd3);
      step(1, "b_err_ack",    0, 5'b00100, 3'b000, 2'b00, 0, 1, 2'd3, 16'd3);
      step(1, "b_err_hold",   0, 5'b01000, 3'b000, 2'b00, 0, 1, 2'd3, 16'd3);
      step(1, "b_clr",        1, 5'b00000, 3'b000, 2'b00, 0, 0, 2'd0, 16'd0);
      step(1, "b_run",        0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd0);
      step(1, "b_lu1",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd0);
      step(1, "b_lu2",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd1);
      step(1, "b_lu3",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd2);
      step(1, "b_lu4",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd3);
      step(1, "b_lu5",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd3);
      step(1, "b_lu6",        0, 5'b00001, 3'b001, 2'b01, 0, 0, 2'd0, 16'd3);
      step(1, "b_sat",        0, 5'b00000, 3'b111, 2'b00, 0, 0, 2'd0, 16'd3);

      for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) begin
         @(posedge clk);
      end
      if (sb.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 3-stage core. It drives the load enables (`ld_str`) and bubble-insert (flush) controls of the PC, IF/ID and ID/EX pipeline registers, which are built from the parameterised bit-slice registers. It resolves branch flushes, load-use stalls, halts and multi-cycle memory handshakes, and it detects memory timeouts. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `TIMEOUT`, 16: number of consecutive un-acked `MEM_WAIT` cycles before the error state; legal range 1..255.
- `CW`, 16: width of `stall_cnt`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `clr`  in  1  reset; asynchronous, active-high.
- `halt`  in  1  level request to freeze the pipeline.
- `mem_req`  in  1  EX stage needs a multi-cycle memory access.
- `mem_ack`  in  1  memory access complete; sampled only in `MEM_WAIT`.
- `branch_taken`  in  1  EX resolved a taken branch.
- `ld_use_hazard`  in  1  ID instruction depends on the load currently in EX.
- `pc_ld`  out  1  PC register load enable.
- `ifid_ld`  out  1  IF/ID load enable.
- `idex_ld`  out  1  ID/EX load enable.
- `ifid_flush`  out  1  IF/ID loads a NOP instead of data on the next edge.
- `idex_flush`  out  1  ID/EX loads a NOP instead of data on the next edge.
- `mem_go`  out  1  one-cycle memory start strobe.
- `err`  out  1  sticky memory-timeout flag.
- `state_o`  out  2  current state: RUN=0, MEM_WAIT=1, HALT=2, ERR=3.
- `stall_cnt`  out  CW  saturating count of stall cycles.

## Operation
- **Structure.**
  - State, wait counter (8 bits) and `stall_cnt` are registered.
  - The enable and flush outputs are combinational in the current state and current inputs.
  - A flush has effect only when the matching `ld` is 1.
- **While `clr` is high.**
  - Every output is 0.
  - State is forced to RUN; the wait counter and `stall_cnt` are 0.
  - Assertion mid-operation (including in `MEM_WAIT` or ERR) aborts it immediately.
- **RUN.** Fixed priority: `halt` > `mem_req` > `branch_taken` > `ld_use_hazard` > normal.
  - `halt`: all `ld` = 0; next state HALT.
  - `mem_req`: all `ld` = 0; `mem_go` = 1; next state `MEM_WAIT`; wait counter cleared to 0.
  - `branch_taken`: all `ld` = 1; `ifid_flush` = 1 and `idex_flush` = 1 (two bubbles); PC takes the target.
  - `ld_use_hazard`: `pc_ld` = 0, `ifid_ld` = 0, `idex_ld` = 1, `idex_flush` = 1 (one bubble, fetch held).
  - Normal: all `ld` = 1; both flushes = 0.
- **MEM_WAIT.** All `ld` = 0; `mem_go` = 0.
  - `mem_ack` = 1: next state RUN; the pipeline advances on the following cycle.
  - Otherwise, if wait counter = `TIMEOUT`-1: next state ERR.
  - Otherwise: wait counter increments.
  - ERR is therefore entered after exactly `TIMEOUT` un-acked `MEM_WAIT` cycles.
  - `halt` and `branch_taken` are ignored in this state.
- **HALT.** All `ld` = 0. When `halt` = 0, next state is RUN. Pending `mem_req` is re-evaluated in RUN.
- **ERR.** All `ld` = 0 and `err` = 1. Exit only via `clr`.
- **`stall_cnt`.** Increments by 1 on each edge where state is RUN or `MEM_WAIT` and `pc_ld` = 0. It holds at all-ones (saturates, no wrap). It does not count in HALT or ERR.
- **`mem_ack`** is ignored outside `MEM_WAIT`.

## Timing
- State transitions take effect one cycle after the inputs are sampled.
- Enable and flush outputs respond in the same cycle as the inputs (zero latency).
- `mem_go` is high for exactly one cycle per request: the RUN cycle in which `mem_req` is accepted.
- Minimum memory access costs 2 frozen cycles: the `mem_go` cycle plus one `MEM_WAIT` cycle with `mem_ack`.
- After `clr` falls, the first edge evaluates in RUN. With all inputs low, all `ld` = 1 in that cycle.
- A `clr` assertion pulls all outputs low asynchronously, without waiting for a clock edge.
- `err` rises on the first cycle in ERR and is registered-state driven (glitch-free).

## Test plan
1. **Reset.** Pulse `clr` mid-cycle while in `MEM_WAIT` -> all outputs 0 immediately. After release, `state_o` = 0 and `stall_cnt` = 0.
2. **Branch and hazard together.** `branch_taken` = 1 and `ld_use_hazard` = 1 in the same RUN cycle -> `pc_ld` = `ifid_ld` = `idex_ld` = 1, both flushes = 1, `stall_cnt` unchanged.
3. **Load-use.** `ld_use_hazard` = 1 for 3 cycles -> `pc_ld` = `ifid_ld` = 0, `idex_flush` = 1 each cycle, `stall_cnt` = 3.
4. **Memory handshake.** `mem_req` with `mem_ack` after 4 `MEM_WAIT` cycles -> `mem_go` high 1 cycle, 5 frozen cycles, `stall_cnt` = 5, back to RUN, `err` = 0.
5. **Timeout.** `TIMEOUT` = 3, `mem_req` and never ack -> ERR entered after 3 `MEM_WAIT` cycles, `err` = 1 held; a later `mem_ack` has no effect; `clr` clears it.
6. **Halt and saturation.**
   - `halt` and `mem_req` high in the same cycle -> HALT, `mem_go` = 0. Drop `halt` -> RUN, then `mem_go` pulses.
   - With `CW` = 2, 6 stall cycles -> `stall_cnt` = 3.
